axi_lsu_master: RTL
===================

// Module: axi_lsu_master
// PURPOSE
//  Single-outstanding AXI4 initiator turning LSU load/store requests into one-beat AXI transactions.
//  Sits between the core LSU and the SRAM/peripheral AXI slaves; it is the master end of that bus.
//  Generates WSTRB from size/offset, lane-aligns store data, and extracts and sign/zero-extends load data.
// PARAMETERS
//  ADDR_WIDTH  32     address width (AXADDR and req_addr)
//  DATA_WIDTH  32     data width; only 32 is supported, giving a 4-bit strobe
//  AXI_ID      4'h0   constant driven on AWID and ARID; returned BID/RID are ignored
// PORTS
//  M_AXI_ACLK     in   1   clock
//  M_AXI_ARESETN  in   1   async active-low reset
//  req_valid      in   1   LSU request valid
//  req_ready      out  1   block can accept a request (IDLE state)
//  req_wen        in   1   1=store, 0=load
//  req_size       in   2   0=byte 1=half 2=word; 3 is illegal and treated as misaligned
//  req_signed     in   1   sign-extend load result (byte/half only)
//  req_addr       in   ADDR_WIDTH  byte address
//  req_wdata      in   32  store data, LSB-justified
//  resp_valid     out  1   one-cycle pulse: request complete
//  resp_rdata     out  32  load result, extended; 0 for stores and errors
//  resp_err       out  1   with resp_valid: misaligned, or RESP[1]=1 (SLVERR/DECERR)
//  M_AXI_AW*: AWADDR/AWVALID/AWREADY/AWID/AWLEN/AWSIZE/AWBURST; W*: WDATA/WSTRB/WVALID/WREADY/WLAST
//  M_AXI_B*: BRESP/BVALID/BREADY/BID; AR*: ARADDR/ARVALID/ARREADY/ARID/ARLEN/ARSIZE/ARBURST
//  M_AXI_R*: RDATA/RRESP/RVALID/RREADY/RID/RLAST; widths follow AXI4 with 4-bit IDs
// BEHAVIOUR
//  Reset (async assert): state=IDLE; all VALID/READY outputs 0; resp_valid=0; resp_err=0; resp_rdata=0.
//  All AXI and resp outputs are registered. Constant outputs: AxLEN=0, AxBURST=INCR(01), WLAST=1, AxSIZE=req_size.
//  IDLE: req_ready=1. When req_valid, latch addr/size/signed/wdata/wen; check alignment.
//   Alignment: half requires addr[0]=0, word requires addr[1:0]=0, size 3 is always misaligned.
//   Misaligned -> ERR; issues no bus activity; resp_valid+resp_err fire the next cycle.
//   Load -> RD_ADDR with ARVALID=1 the next cycle. Store -> WR_REQ with AWVALID=WVALID=1 the next cycle.
//  WSTRB: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111.
//   WDATA = req_wdata << (8*off), where off=addr[1:0].
//  WR_REQ: AWVALID and WVALID drop independently, each in the cycle after its own handshake.
//   Once both have handshaken (same or different cycles) -> WR_RESP.
//   AW and W must never be re-issued.
//  WR_RESP: BREADY=1. On BVALID -> DONE with err=BRESP[1].
//  RD_ADDR: hold ARVALID and ARADDR until ARREADY, then -> RD_DATA.
//  RD_DATA: RREADY=1. On RVALID, shift RDATA right by 8*off, mask to size, extend per req_signed -> DONE.
//   err=RRESP[1]. RRESP=2'b01 counts as success.
//  DONE/ERR: one-cycle resp_valid, then IDLE; req_ready is low in these states.
//   Back-to-back requests are therefore spaced by at least 1 idle cycle.
//  Latency with zero-wait slave: a load accepted at cycle 0 gives ARVALID at cycle 1.
//   resp_valid arrives at the first cycle after the R handshake.
//  AXI stability: no VALID deasserts or payload change before its READY.
//   READY may be high before VALID; the block must not depend on READY.
//  Reset mid-transaction: all valids drop immediately; no completion is reported.
//  Unexpected BVALID/RVALID outside WR_RESP/RD_DATA is ignored (BREADY/RREADY=0).
// STRUCTURE
//  Shared package npu_axi_pkg holds:
//   - state typedef {IDLE,RD_ADDR,RD_DATA,WR_REQ,WR_RESP,DONE,ERR}
//   - SIZE_B/H/W constants, BURST_INCR, and RESP_OKAY/EXOKAY/SLVERR/DECERR
//  One natural sub-module, lsu_lane_align (combinational), holds:
//   - strobe generation, store shift, load extract/extend, and misalignment check
// TESTING
//  Word store 0x8000_0004 data 0xDEADBEEF with AW/W ready immediately, BRESP=01:
//   -> WSTRB=1111, WDATA=0xDEADBEEF, single resp_valid with err=0
//  Byte store addr 0x..3 data 0xA5 with WREADY 3 cycles before AWREADY:
//   -> WSTRB=1000, WDATA=0xA5000000; WVALID drops after its handshake; AWVALID holds; B accepted once
//  Signed half load addr 0x..2 with RDATA=0x8001_1234 after ARREADY delayed 2 cycles:
//   -> resp_rdata=0xFFFF8001; ARADDR stable while waiting
//  Misaligned word load addr 0x..1 -> no ARVALID ever; resp_valid+resp_err at cycle 1
//  Load with RRESP=2'b10 -> resp_err=1, resp_rdata=0; next request accepted after the DONE cycle
//  Reset asserted while in WR_REQ -> AWVALID/WVALID/resp_valid go 0 asynchronously; req_ready=1 after release

Source files
------------

// File: rtl/npu_axi_pkg.sv
// Shared types and constants for the LSU-side AXI4 initiator.
package npu_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lsu_master_if.sv
// AXI4 single-beat bus between the LSU initiator and its slaves.
// Handshake: a beat transfers on a rising edge where VALID and READY are both
// high; VALID and payload hold until then, READY may rise before VALID.
interface axi_lsu_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [3:0]              awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [3:0]              bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [3:0]              arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [3:0]              rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit bus: store strobe/shift, load extract/extend,
// and the alignment check for the incoming request.
module lsu_lane_align
  import npu_axi_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic        misaligned,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata_aligned,
  output logic [31:0] ld_rdata_ext
);

  logic [31:0] ld_shifted;

  always_comb begin
    misaligned = 1'b0;
    st_wstrb   = 4'b0000;
    case (st_size)
      SIZE_B: st_wstrb = 4'b0001 << st_off;
      SIZE_H: begin
        st_wstrb   = 4'b0011 << st_off;
        misaligned = st_off[0];
      end
      SIZE_W: begin
        st_wstrb   = 4'b1111;
        misaligned = |st_off;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign st_wdata_aligned = st_wdata << {st_off, 3'b000};
  assign ld_shifted       = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_rdata_ext = ld_shifted;
    case (ld_size)
      SIZE_B: ld_rdata_ext = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
      SIZE_H: ld_rdata_ext = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_rdata_ext = ld_shifted;
    endcase
  end

endmodule

// File: rtl/axi_lsu_master.sv
// Single-outstanding AXI4 initiator: one LSU load/store becomes one single-beat
// AXI transaction, completed by a one-cycle resp_valid pulse.
module axi_lsu_master
  import npu_axi_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] AXI_ID     = 4'h0
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output state_t                state_dbg,
  axi_lsu_master_if.master      m_axi
);

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        signed_q;

  logic        misaligned;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata_aligned;
  logic [31:0] ld_rdata_ext;
  logic        aw_done;
  logic        w_done;
  logic        unused_sink;

  lsu_lane_align u_lane (
    .st_off           (req_addr[1:0]),
    .st_size          (req_size),
    .st_wdata         (req_wdata),
    .ld_off           (off_q),
    .ld_size          (size_q),
    .ld_signed        (signed_q),
    .ld_rdata         (m_axi.rdata),
    .misaligned       (misaligned),
    .st_wstrb         (st_wstrb),
    .st_wdata_aligned (st_wdata_aligned),
    .ld_rdata_ext     (ld_rdata_ext)
  );

  assign m_axi.awid    = AXI_ID;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.arid    = AXI_ID;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arburst = BURST_INCR;

  assign req_ready = (state == IDLE);
  assign state_dbg = state;
  assign unused_sink = ^{m_axi.bid, m_axi.rid, m_axi.rlast, m_axi.bresp[0], m_axi.rresp[0]};

  // A channel counts as done once its VALID has dropped or is handshaking now,
  // so AW and W may complete in either order without being re-issued.
  assign aw_done = !m_axi.awvalid || m_axi.awready;
  assign w_done  = !m_axi.wvalid  || m_axi.wready;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state          <= IDLE;
      off_q          <= 2'd0;
      size_q         <= 2'd0;
      signed_q       <= 1'b0;
      m_axi.awaddr   <= '0;
      m_axi.awsize   <= 3'd0;
      m_axi.awvalid  <= 1'b0;
      m_axi.wdata    <= '0;
      m_axi.wstrb    <= '0;
      m_axi.wvalid   <= 1'b0;
      m_axi.bready   <= 1'b0;
      m_axi.araddr   <= '0;
      m_axi.arsize   <= 3'd0;
      m_axi.arvalid  <= 1'b0;
      m_axi.rready   <= 1'b0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q      <= req_addr[1:0];
            size_q     <= req_size;
            signed_q   <= req_signed;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            if (misaligned) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_wen) begin
              state         <= WR_REQ;
              m_axi.awaddr  <= req_addr;
              m_axi.awsize  <= {1'b0, req_size};
              m_axi.awvalid <= 1'b1;
              m_axi.wdata   <= st_wdata_aligned;
              m_axi.wstrb   <= st_wstrb;
              m_axi.wvalid  <= 1'b1;
            end else begin
              state         <= RD_ADDR;
              m_axi.araddr  <= req_addr;
              m_axi.arsize  <= {1'b0, req_size};
              m_axi.arvalid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            state        <= WR_RESP;
            m_axi.bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_axi.bvalid) begin
            state        <= DONE;
            m_axi.bready <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= m_axi.bresp[1];
            resp_rdata   <= '0;
          end
        end
        RD_ADDR: begin
          if (m_axi.arready) begin
            state         <= RD_DATA;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (m_axi.rvalid) begin
            state        <= DONE;
            m_axi.rready <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= m_axi.rresp[1];
            resp_rdata   <= m_axi.rresp[1] ? '0 : ld_rdata_ext;
          end
        end
        DONE, ERR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule
